// File: rtl/wm8731_i2c_master_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// wm8731_i2c_master_pkg : shared FSM encodings and packet layout for the
//                         WM8731 I2C control-write master.  Rev 1.0
// ----------------------------------------------------------------------------
package wm8731_i2c_master_pkg;

  typedef enum logic [2:0] {
    I2C_IDLE  = 3'd0,
    I2C_START = 3'd1,
    I2C_DATA  = 3'd2,
    I2C_ACK   = 3'd3,
    I2C_STOP  = 3'd4
  } i2c_state_t;

  localparam logic [7:0] WM8731_I2C_WR_ADDR = 8'h34;

  // Packet is [23:16] device byte, [15:8] addr/data MSB, [7:0] data LSB
  localparam int         PKT_W     = 24;
  localparam int         PKT_MSB   = PKT_W - 1;
  localparam logic [2:0] LAST_BIT  = 3'd7;
  localparam logic [1:0] LAST_BYTE = 2'd2;

endpackage
`default_nettype wire

// File: rtl/wm8731_i2c_master_tick_gen.sv
`default_nettype none
// ----------------------------------------------------------------------------
// wm8731_i2c_master_tick_gen : CLK_DIV prescaler producing SCL quarter-phase
//                              ticks and the current quarter index.  Rev 1.0
// ----------------------------------------------------------------------------
module wm8731_i2c_master_tick_gen #(
  parameter int CLK_DIV = 125
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       enable,
  input  logic       phase_clr,
  output logic       tick,
  output logic [1:0] quarter
);
  localparam int            CW       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] count;

  assign tick = enable && (count == CNT_LAST);

  // phase_clr lets short states (START, STOP) restart the quarter sequence
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      count   <= '0;
      quarter <= 2'd0;
    end else if (!enable) begin
      count   <= '0;
      quarter <= 2'd0;
    end else if (tick) begin
      count   <= '0;
      quarter <= phase_clr ? 2'd0 : quarter + 2'd1;
    end else begin
      count   <= count + CW'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/wm8731_i2c_master.sv
`default_nettype none
// ----------------------------------------------------------------------------
// wm8731_i2c_master : write-only I2C master sending one 24-bit WM8731 control
//                     packet as START, 3 x (8 bits + ACK), STOP.  Rev 1.0
// ----------------------------------------------------------------------------
module wm8731_i2c_master
  import wm8731_i2c_master_pkg::*;
#(
  parameter int CLK_DIV = 125
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             i2c_start,
  input  logic [PKT_W-1:0] i2c_packet,
  output logic             i2c_busy,
  output logic             i2c_done,
  output logic             i2c_nack,
  output logic             scl_oe,
  output logic             sda_oe,
  input  logic             sda_in
);
  i2c_state_t       state;
  logic [PKT_W-1:0] shift;
  logic [2:0]       bit_cnt;
  logic [1:0]       byte_cnt;
  logic [1:0]       sda_sync;
  logic             ack_sample;
  logic             tick;
  logic             phase_clr;
  logic [1:0]       quarter;

  assign phase_clr = ((state == I2C_START) && (quarter == 2'd1)) ||
                     ((state == I2C_STOP)  && (quarter == 2'd2));

  wm8731_i2c_master_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick_gen (
    .Clk       (Clk),
    .Reset_n   (Reset_n),
    .enable    (state != I2C_IDLE),
    .phase_clr (phase_clr),
    .tick      (tick),
    .quarter   (quarter)
  );

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) sda_sync <= 2'b11;
    else          sda_sync <= {sda_sync[0], sda_in};
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state      <= I2C_IDLE;
      shift      <= '0;
      bit_cnt    <= 3'd0;
      byte_cnt   <= 2'd0;
      scl_oe     <= 1'b0;
      sda_oe     <= 1'b0;
      i2c_busy   <= 1'b0;
      i2c_done   <= 1'b0;
      i2c_nack   <= 1'b0;
      ack_sample <= 1'b0;
    end else begin
      i2c_done   <= 1'b0;
      // High during the first clock of ACK q3, where the slave's answer is taken
      ack_sample <= tick && (state == I2C_ACK) && (quarter == 2'd2);
      if (ack_sample && sda_sync[1]) i2c_nack <= 1'b1;

      case (state)
        I2C_IDLE: begin
          if (i2c_start) begin
            state    <= I2C_START;
            shift    <= i2c_packet;
            bit_cnt  <= 3'd0;
            byte_cnt <= 2'd0;
            i2c_nack <= 1'b0;
            i2c_busy <= 1'b1;
            scl_oe   <= 1'b0;
            sda_oe   <= 1'b1;
          end
        end
        I2C_START: begin
          if (tick && (quarter == 2'd1)) begin
            state  <= I2C_DATA;
            scl_oe <= 1'b1;
            sda_oe <= ~shift[PKT_MSB];
          end
        end
        I2C_DATA: begin
          if (tick) begin
            case (quarter)
              2'd1: scl_oe <= 1'b0;
              2'd3: begin
                shift  <= shift << 1;
                scl_oe <= 1'b1;
                if (bit_cnt == LAST_BIT) begin
                  bit_cnt <= 3'd0;
                  state   <= I2C_ACK;
                  sda_oe  <= 1'b0;
                end else begin
                  bit_cnt <= bit_cnt + 3'd1;
                  sda_oe  <= ~shift[PKT_MSB-1];
                end
              end
              default: ;
            endcase
          end
        end
        I2C_ACK: begin
          if (tick) begin
            case (quarter)
              2'd1: scl_oe <= 1'b0;
              2'd3: begin
                scl_oe <= 1'b1;
                if (!i2c_nack) byte_cnt <= byte_cnt + 2'd1;
                if (i2c_nack || (byte_cnt == LAST_BYTE)) begin
                  state  <= I2C_STOP;
                  sda_oe <= 1'b1;
                end else begin
                  state  <= I2C_DATA;
                  sda_oe <= ~shift[PKT_MSB];
                end
              end
              default: ;
            endcase
          end
        end
        I2C_STOP: begin
          if (tick) begin
            case (quarter)
              2'd0: scl_oe <= 1'b0;
              2'd1: sda_oe <= 1'b0;
              2'd2: begin
                state    <= I2C_IDLE;
                i2c_done <= 1'b1;
                i2c_busy <= 1'b0;
              end
              default: ;
            endcase
          end
        end
        default: state <= I2C_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_wm8731_i2c_master.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_wm8731_i2c_master : directed bench with an I2C slave model and bus
//                        protocol monitor for wm8731_i2c_master.  Rev 1.0
// ----------------------------------------------------------------------------
module tb_wm8731_i2c_master;
  import wm8731_i2c_master_pkg::*;

  localparam int CLK_DIV = 4;
  localparam int HALF    = 2 * CLK_DIV;

  logic        Clk        = 1'b0;
  logic        Reset_n    = 1'b0;
  logic        i2c_start  = 1'b0;
  logic [23:0] i2c_packet = 24'h0;
  logic        i2c_busy, i2c_done, i2c_nack, scl_oe, sda_oe;
  logic        slv_low    = 1'b0;
  logic        sda_line;

  assign sda_line = ~(sda_oe | slv_low);

  wm8731_i2c_master #(.CLK_DIV(CLK_DIV)) dut (
    .Clk        (Clk),
    .Reset_n    (Reset_n),
    .i2c_start  (i2c_start),
    .i2c_packet (i2c_packet),
    .i2c_busy   (i2c_busy),
    .i2c_done   (i2c_done),
    .i2c_nack   (i2c_nack),
    .scl_oe     (scl_oe),
    .sda_oe     (sda_oe),
    .sda_in     (sda_line)
  );

  always #5 Clk = ~Clk;

  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  // Slave model (ACKs only device address 0x34) plus SCL/SDA protocol monitor
  int          starts = 0, stops = 0, proto_err = 0, short_lows = 0;
  int          nbytes = 0, bitpos = 0, last_n = 0;
  int          last_rise = 0, last_fall = 0;
  logic [7:0]  cur = 8'h0;
  logic [23:0] rx_pkt = 24'h0, last_pkt = 24'h0;
  logic        addressed = 1'b0, in_ack = 1'b0, active = 1'b0;
  logic        rise_v = 1'b0, fall_v = 1'b0;
  logic        p_scl = 1'b1, p_sda = 1'b1, scl_now, sda_now;

  always begin
    @(posedge Clk);
    #1;
    scl_now = ~scl_oe;
    sda_now = ~(sda_oe | slv_low);
    if (!Reset_n) begin
      active = 1'b0; in_ack = 1'b0; slv_low = 1'b0;
      rise_v = 1'b0; fall_v = 1'b0; bitpos = 0;
    end else if (p_scl && scl_now && p_sda && !sda_now) begin
      starts++;
      active = 1'b1; bitpos = 0; nbytes = 0; in_ack = 1'b0;
      rise_v = 1'b0; fall_v = 1'b0; addressed = 1'b0; rx_pkt = 24'h0;
    end else if (p_scl && scl_now && !p_sda && sda_now) begin
      stops++;
      active = 1'b0; rise_v = 1'b0; fall_v = 1'b0;
      last_pkt = rx_pkt; last_n = nbytes;
    end else if (!p_scl && scl_now) begin
      if (fall_v) begin
        if (cyc - last_fall == CLK_DIV) short_lows++;
        else if (cyc - last_fall != HALF) proto_err++;
      end
      last_rise = cyc; rise_v = 1'b1; fall_v = 1'b0;
      if (active && bitpos < 8) begin
        cur = {cur[6:0], sda_now};
        bitpos++;
        if (bitpos == 8) begin
          if (nbytes == 0) addressed = (cur == WM8731_I2C_WR_ADDR);
          rx_pkt = {rx_pkt[15:0], cur};
          nbytes++;
        end
      end
    end else if (p_scl && !scl_now) begin
      if (rise_v && (cyc - last_rise != HALF)) proto_err++;
      last_fall = cyc; fall_v = 1'b1; rise_v = 1'b0;
      if (active && bitpos == 8) begin
        if (in_ack) begin
          slv_low = 1'b0; in_ack = 1'b0; bitpos = 0;
        end else begin
          in_ack = 1'b1; slv_low = addressed;
        end
      end
    end
    p_scl = scl_now;
    p_sda = sda_now;
  end

  int passed = 0, failed = 0, total = 0;
  int t_acc = 0, lat = 0;
  int s0 = 0, p0 = 0, e0 = 0, l0 = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick_n(input int n);
    repeat (n) begin @(posedge Clk); #1; end
  endtask

  task automatic send(input logic [23:0] pkt);
    i2c_packet = pkt;
    i2c_start  = 1'b1;
    @(posedge Clk); #1;
    i2c_start  = 1'b0;
    t_acc      = cyc;
  endtask

  task automatic wait_done();
    int n = 0;
    while (!i2c_done && n < 3000) begin @(posedge Clk); #1; n++; end
    lat = cyc - t_acc;
  endtask

  task automatic snap();
    s0 = starts; p0 = stops; e0 = proto_err; l0 = short_lows;
  endtask

  initial begin
    tick_n(3);
    check("reset_scl_oe", scl_oe, 0);
    check("reset_sda_oe", sda_oe, 0);
    check("reset_busy",   i2c_busy, 0);
    check("reset_done",   i2c_done, 0);
    check("reset_nack",   i2c_nack, 0);
    Reset_n = 1'b1;
    tick_n(5);

    // Reset-register write, with an ignored start pulse mid-transfer
    snap();
    send(24'h341E00);
    check("s1_busy_after_accept", i2c_busy, 1);
    tick_n(100);
    i2c_packet = 24'h34FFFF;
    i2c_start  = 1'b1;
    tick_n(1);
    i2c_start  = 1'b0;
    wait_done();
    check("s1_latency",     lat, 452);
    check("s1_nack",        i2c_nack, 0);
    check("s1_busy_done",   i2c_busy, 0);
    tick_n(1);
    check("s1_done_pulse",  i2c_done, 0);
    tick_n(3);
    check("s1_rx_packet",   last_pkt, 24'h341E00);
    check("s1_rx_bytes",    last_n, 3);
    check("s1_starts",      starts - s0, 1);
    check("s1_stops",       stops - p0, 1);
    check("s1_short_low",   short_lows - l0, 1);
    check("s1_proto",       proto_err - e0, 0);
    tick_n(10);

    // Wrong device address is NACKed, then a start on the done cycle
    snap();
    send(24'h360000);
    wait_done();
    check("s2_latency",     lat, 164);
    check("s2_nack",        i2c_nack, 1);
    check("s2_done",        i2c_done, 1);
    send(24'h340C00);
    check("s4_nack_clear",  i2c_nack, 0);
    check("s4_busy",        i2c_busy, 1);
    check("s2_rx_packet",   last_pkt, 24'h000036);
    check("s2_rx_bytes",    last_n, 1);
    wait_done();
    check("s4_latency",     lat, 452);
    check("s4_nack",        i2c_nack, 0);
    tick_n(3);
    check("s4_rx_packet",   last_pkt, 24'h340C00);
    check("s4_rx_bytes",    last_n, 3);
    check("s24_starts",     starts - s0, 2);
    check("s24_stops",      stops - p0, 2);
    check("s24_short_low",  short_lows - l0, 2);
    check("s24_proto",      proto_err - e0, 0);
    tick_n(10);

    // Asynchronous reset during bit 5 of the second byte, then recovery
    send(24'h340E4A);
    tick_n(233);
    check("s5_scl_low_pre",  scl_oe, 1);
    check("s5_busy_pre",     i2c_busy, 1);
    #2 Reset_n = 1'b0;
    #1;
    check("s5_rst_scl_oe",   scl_oe, 0);
    check("s5_rst_sda_oe",   sda_oe, 0);
    check("s5_rst_busy",     i2c_busy, 0);
    tick_n(3);
    Reset_n = 1'b1;
    tick_n(5);
    snap();
    send(24'h34127F);
    wait_done();
    check("s5_latency",      lat, 452);
    check("s5_nack",         i2c_nack, 0);
    tick_n(3);
    check("s5_rx_packet",    last_pkt, 24'h34127F);
    check("s5_rx_bytes",     last_n, 3);
    check("s5_stops",        stops - p0, 1);
    check("s5_proto",        proto_err - e0, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire
